// File: rtl/sram_dma_responder.sv
// Single-port 32-bit word SRAM with a one-cycle registered read port and a word-copy DMA engine.
// The CPU port always wins; the engine only touches memory in cycles where sram_EN is low.
module sram_dma_responder #(
    parameter int AW    = 16,
    parameter int DEPTH = 65536
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] sram_ADDR,
    input  logic [31:0]   sram_DI,
    input  logic          sram_EN,
    input  logic          sram_WE,
    output logic [31:0]   sram_DO,
    input  logic          dma_start,
    input  logic [AW-1:0] dma_src,
    input  logic [AW-1:0] dma_dst,
    input  logic [AW-1:0] dma_len,
    output logic          dma_busy,
    output logic          dma_done
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cur_src, cur_dst, remaining;
    logic [31:0]   data_q;
    logic [31:0]   mem [DEPTH];

    logic          dma_rd, dma_wr, mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    // Engine accesses are suppressed under reset so an in-flight copy cannot land one more word.
    always_comb begin
        dma_rd    = (state == RD) && !sram_EN && !reset;
        dma_wr    = (state == WR) && !sram_EN && !reset;
        mem_we    = (sram_EN && sram_WE) || dma_wr;
        mem_re    = (sram_EN && !sram_WE) || dma_rd;
        mem_addr  = sram_ADDR;
        mem_wdata = sram_DI;
        if (dma_rd) begin
            mem_addr = cur_src;
        end
        if (dma_wr) begin
            mem_addr  = cur_dst;
            mem_wdata = data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Read-first: a same-edge write never affects the word returned here.
    always_ff @(posedge clk) begin
        if (reset) begin
            sram_DO <= '0;
        end else if (mem_re) begin
            sram_DO <= mem[mem_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (dma_start) state_nxt = (dma_len == '0) ? DONE : RD;
            RD:      if (!sram_EN) state_nxt = CAP;
            CAP:     state_nxt = WR;
            WR:      if (!sram_EN) state_nxt = (remaining > AW'(1)) ? RD : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
            data_q    <= '0;
        end else begin
            if (state == IDLE && dma_start) begin
                cur_src   <= dma_src;
                cur_dst   <= dma_dst;
                remaining <= dma_len;
            end
            if (state == CAP) begin
                data_q <= sram_DO;
            end
            if (dma_wr) begin
                cur_src   <= cur_src + AW'(1);
                cur_dst   <= cur_dst + AW'(1);
                remaining <= remaining - AW'(1);
            end
        end
    end

    assign dma_busy = (state != IDLE);
    assign dma_done = (state == DONE);

endmodule

// File: tb/tb_sram_dma_responder.sv
// Directed bench for sram_dma_responder: a word-level memory/copy model checked every cycle,
// plus literal read-back and timing expectations for each scenario.
module tb_sram_dma_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sram_ADDR;
    logic [31:0] sram_DI;
    logic        sram_EN, sram_WE;
    logic [31:0] sram_DO;
    logic        dma_start;
    logic [15:0] dma_src, dma_dst, dma_len;
    logic        dma_busy, dma_done;

    always #5 clk = ~clk;

    sram_dma_responder #(.AW(16), .DEPTH(65536)) dut (
        .clk(clk), .reset(reset),
        .sram_ADDR(sram_ADDR), .sram_DI(sram_DI), .sram_EN(sram_EN), .sram_WE(sram_WE),
        .sram_DO(sram_DO),
        .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
        .dma_busy(dma_busy), .dma_done(dma_done)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Copy model: a copy is a list of memory steps (read, capture, write per word) and a done step.
    // Read and write steps only advance in cycles the CPU leaves the port free.
    typedef enum int {S_R, S_C, S_W, S_D} step_t;
    step_t       steps[$];
    logic [31:0] mm [logic [15:0]];
    logic [15:0] m_src, m_dst;
    logic [31:0] m_word;
    bit          m_word_known;
    logic [31:0] exp_do = '0;
    bit          do_known = 0;
    bit          model_live = 0;

    always @(posedge clk) begin
        if (reset) begin
            steps.delete();
            exp_do     = '0;
            do_known   = 1;
            model_live = 1;
        end else begin
            if (sram_EN && sram_WE) begin
                mm[sram_ADDR] = sram_DI;
            end else if (sram_EN) begin
                do_known = mm.exists(sram_ADDR);
                exp_do   = do_known ? mm[sram_ADDR] : '0;
            end
            if (steps.size() == 0) begin
                if (dma_start) begin
                    m_src = dma_src;
                    m_dst = dma_dst;
                    for (int i = 0; i < int'(dma_len); i++) begin
                        steps.push_back(S_R);
                        steps.push_back(S_C);
                        steps.push_back(S_W);
                    end
                    steps.push_back(S_D);
                end
            end else begin
                case (steps[0])
                    S_R: if (!sram_EN) begin
                        m_word_known = mm.exists(m_src);
                        m_word       = m_word_known ? mm[m_src] : '0;
                        exp_do       = m_word;
                        do_known     = m_word_known;
                        void'(steps.pop_front());
                    end
                    S_W: if (!sram_EN) begin
                        if (m_word_known) mm[m_dst] = m_word;
                        else mm.delete(m_dst);
                        m_src = m_src + 16'd1;
                        m_dst = m_dst + 16'd1;
                        void'(steps.pop_front());
                    end
                    default: void'(steps.pop_front());
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            bit eb, ed;
            eb = (steps.size() != 0);
            ed = eb ? (steps[0] == S_D) : 1'b0;
            chk("model busy", {31'b0, dma_busy}, {31'b0, eb});
            chk("model done", {31'b0, dma_done}, {31'b0, ed});
            if (do_known) chk("model sram_DO", sram_DO, exp_do);
        end
    end

    task automatic cpu_write(input logic [15:0] a, input logic [31:0] d);
        sram_EN = 1; sram_WE = 1; sram_ADDR = a; sram_DI = d;
        @(negedge clk);
        sram_EN = 0; sram_WE = 0;
    endtask

    task automatic cpu_read(input string name, input logic [15:0] a, input logic [31:0] exp);
        sram_EN = 1; sram_WE = 0; sram_ADDR = a;
        @(negedge clk);
        sram_EN = 0;
        chk(name, sram_DO, exp);
    endtask

    // mode 0: idle CPU; 1: CPU on odd cycles (first one writes 0x55 to 0x101);
    // 2: extra dma_start pulses in cycle 3 and in the done cycle.
    task automatic run_dma(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                           input int mode, output int done_at, output int busy_cnt);
        bit finished;
        dma_src = s; dma_dst = d; dma_len = n; dma_start = 1;
        @(negedge clk);
        dma_start = 0;
        done_at = -1; busy_cnt = 0; finished = 0;
        for (int k = 1; k <= 120 && !finished; k++) begin
            if (dma_done) done_at = k;
            if (dma_busy) busy_cnt++;
            if (!dma_busy) begin
                finished = 1;
            end else begin
                sram_EN = 0; sram_WE = 0;
                if (mode == 1 && (k % 2) == 1) begin
                    sram_EN   = 1;
                    sram_WE   = (k == 1);
                    sram_ADDR = (k == 1) ? 16'h0101 : 16'h0010;
                    sram_DI   = 32'h55;
                end
                if (mode == 2 && (k == 3 || dma_done)) begin
                    dma_start = 1; dma_src = 16'h0300; dma_dst = 16'h0500; dma_len = 16'd1;
                end else begin
                    dma_start = 0;
                end
                @(negedge clk);
            end
        end
        sram_EN = 0; sram_WE = 0; dma_start = 0;
        if (!finished) chk("copy timeout", 32'd0, 32'd1);
    endtask

    int done_at, busy_cnt;

    initial begin
        reset = 1; sram_ADDR = '0; sram_DI = '0; sram_EN = 0; sram_WE = 0;
        dma_start = 0; dma_src = '0; dma_dst = '0; dma_len = '0;
        @(negedge clk); @(negedge clk);
        chk("reset sram_DO", sram_DO, 32'h0);
        chk("reset busy", {31'b0, dma_busy}, 32'h0);
        chk("reset done", {31'b0, dma_done}, 32'h0);
        reset = 0;

        cpu_write(16'h0010, 32'hDEADBEEF);
        cpu_read("read after write", 16'h0010, 32'hDEADBEEF);
        cpu_write(16'h0010, 32'h1);
        chk("DO holds on write", sram_DO, 32'hDEADBEEF);
        cpu_read("new word visible", 16'h0010, 32'h1);

        for (int i = 0; i < 4; i++) cpu_write(16'h0100 + 16'(i), 32'(i + 1));
        run_dma(16'h0100, 16'h0200, 16'd4, 0, done_at, busy_cnt);
        chk("uncontended done cycle", 32'(done_at), 32'd13);
        chk("uncontended busy cycles", 32'(busy_cnt), 32'd13);
        for (int i = 0; i < 4; i++) cpu_read("uncontended data", 16'h0200 + 16'(i), 32'(i + 1));

        for (int i = 0; i < 4; i++) cpu_write(16'h0200 + 16'(i), 32'h0);
        run_dma(16'h0100, 16'h0200, 16'd4, 1, done_at, busy_cnt);
        chk("contended done cycle", 32'(done_at), 32'd17);
        chk("contended busy cycles", 32'(busy_cnt), 32'd17);
        cpu_read("contended w0", 16'h0200, 32'h1);
        cpu_read("contended w1", 16'h0201, 32'h55);
        cpu_read("contended w2", 16'h0202, 32'h3);
        cpu_read("contended w3", 16'h0203, 32'h4);

        cpu_write(16'h0700, 32'h77);
        run_dma(16'h0100, 16'h0700, 16'd0, 0, done_at, busy_cnt);
        chk("len0 done cycle", 32'(done_at), 32'd1);
        chk("len0 busy cycles", 32'(busy_cnt), 32'd1);
        cpu_read("len0 no change", 16'h0700, 32'h77);

        cpu_write(16'hFFFE, 32'hA1); cpu_write(16'hFFFF, 32'hA2); cpu_write(16'h0000, 32'hA3);
        run_dma(16'hFFFE, 16'h0010, 16'd3, 0, done_at, busy_cnt);
        chk("wrap done cycle", 32'(done_at), 32'd10);
        cpu_read("wrap w0", 16'h0010, 32'hA1);
        cpu_read("wrap w1", 16'h0011, 32'hA2);
        cpu_read("wrap w2", 16'h0012, 32'hA3);

        cpu_write(16'h0300, 32'h7);
        for (int i = 1; i < 4; i++) cpu_write(16'h0300 + 16'(i), 32'h9);
        run_dma(16'h0300, 16'h0301, 16'd3, 0, done_at, busy_cnt);
        for (int i = 1; i < 4; i++) cpu_read("overlap", 16'h0300 + 16'(i), 32'h7);

        cpu_write(16'h0500, 32'hAA);
        run_dma(16'h0100, 16'h0400, 16'd2, 2, done_at, busy_cnt);
        chk("start-while-busy done cycle", 32'(done_at), 32'd7);
        chk("start-while-busy busy cycles", 32'(busy_cnt), 32'd7);
        cpu_read("start-while-busy w0", 16'h0400, 32'h1);
        cpu_read("start-while-busy w1", 16'h0401, 32'h55);
        cpu_read("ignored copy untouched", 16'h0500, 32'hAA);

        for (int i = 0; i < 4; i++) cpu_write(16'h0600 + 16'(i), 32'hE0 + 32'(i));
        dma_src = 16'h0100; dma_dst = 16'h0600; dma_len = 16'd4; dma_start = 1;
        @(negedge clk);
        dma_start = 0;
        repeat (8) @(negedge clk);
        chk("pre-reset sram_DO", sram_DO, 32'h3);
        reset = 1;
        @(negedge clk);
        chk("mid-copy reset busy", {31'b0, dma_busy}, 32'h0);
        chk("mid-copy reset done", {31'b0, dma_done}, 32'h0);
        chk("mid-copy reset sram_DO", sram_DO, 32'h0);
        reset = 0;
        cpu_read("reset copy w0", 16'h0600, 32'h1);
        cpu_read("reset copy w1", 16'h0601, 32'h55);
        cpu_read("reset keeps w2", 16'h0602, 32'hE2);
        cpu_read("reset keeps w3", 16'h0603, 32'hE3);
        repeat (3) @(negedge clk);
        chk("idle after reset", {31'b0, dma_busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/sram_dma_responder.md
# sram_dma_responder

Memory-side responder for the CPU controller's SRAM port. It holds the 32-bit word memory and serves CPU reads and writes with a fixed one-cycle read latency. It also contains a word-copy DMA engine that uses the single memory port only in cycles the CPU leaves free. It sits directly under the CPU controller in the top-level and replaces the bare SRAM instance.

## Interface
Parameters:
- `AW`, default 16: address width in words.
- `DEPTH`, default 65536: number of 32-bit words; must equal 2^AW.

Ports:
- `clk`: input, 1 bit. Clock.
- `reset`: input, 1 bit. Synchronous, active-high.
- `sram_ADDR`: input, AW bits. CPU word address.
- `sram_DI`: input, 32 bits. CPU write data.
- `sram_EN`: input, 1 bit. CPU access request this cycle.
- `sram_WE`: input, 1 bit. CPU write strobe; valid only with `sram_EN`.
- `sram_DO`: output, 32 bits. Registered read data.
- `dma_start`: input, 1 bit. Single-cycle copy request.
- `dma_src`: input, AW bits. Source word address.
- `dma_dst`: input, AW bits. Destination word address.
- `dma_len`: input, AW bits. Number of words to copy.
- `dma_busy`: output, 1 bit. Engine active.
- `dma_done`: output, 1 bit. One-cycle completion pulse.

## Operation
Memory array:
- `mem[DEPTH]` of 32-bit words.
- Not cleared by `reset`.

CPU port:
- Has absolute priority.
- Any cycle with `sram_EN=1` belongs to the CPU; the engine does not touch memory in that cycle.
- Write: when `sram_EN` and `sram_WE` are both high at a clock edge, `mem[sram_ADDR] <= sram_DI`.
- Read: at every edge where the port is used with no write (by the CPU or by the engine), `sram_DO <= mem[addr]`.
  - Read-first: a write to the same address in the same cycle returns the old word.
  - On a CPU write cycle or an idle cycle, `sram_DO` holds its previous value.
- `sram_DO` reflects whichever agent read in the previous cycle. The CPU only samples it in the cycle after its own read.

DMA engine states:
- `IDLE`
  - On `dma_start=1`: latch `src`, `dst`, `len` into `cur_src`, `cur_dst`, `remaining`.
  - If `len==0`, go to `DONE`; otherwise go to `RD`.
  - `dma_start` is ignored in every state except `IDLE`.
- `RD`
  - If `sram_EN==0`: read `mem[cur_src]` (drives `sram_DO`) and go to `CAP`.
  - Otherwise stay in `RD`.
- `CAP`
  - `data_q <= sram_DO` unconditionally.
  - Go to `WR`.
- `WR`
  - If `sram_EN==0`:
    - `mem[cur_dst] <= data_q`
    - `cur_src++`, `cur_dst++`, `remaining--`
    - Go to `RD` if `remaining>1`, else `DONE`.
  - Otherwise stay in `WR`.
- `DONE`
  - `dma_done=1` for exactly this cycle.
  - Go to `IDLE`.

Output rules:
- `dma_busy=1` in `RD`, `CAP`, `WR` and `DONE`.

Arithmetic and boundary rules:
- Address counters wrap modulo 2^AW (`0xFFFF+1 -> 0x0000`).
- Overlapping source and destination ranges are copied strictly in ascending address order, word by word. Overlap with `dst>src` therefore propagates copied data forward; this is defined behaviour, not a fault.
- A CPU write to a not-yet-read source word during a copy is visible to the copy. No other coherence is provided.
- `reset` mid-copy:
  - State goes to `IDLE`; `dma_busy` and `dma_done` go to 0; `sram_DO` goes to 0.
  - Words already written stay written; no further writes occur.

## Timing
- Reset values: `sram_DO=0`, `dma_busy=0`, `dma_done=0`; internal counters 0; state `IDLE`.
- CPU read latency: address presented in cycle t is sampled at the edge ending t; the data appears on `sram_DO` during t+1.
- CPU write: takes effect at the edge ending the `WE` cycle. A read of the same address in t+1 returns the new word in t+2.
- DMA, uncontended (`sram_EN=0` throughout):
  - `dma_start` sampled at edge e0.
  - `dma_busy` rises after e0.
  - Each word takes 3 cycles (`RD`, `CAP`, `WR`).
  - `dma_done` is high in cycle 3N+1 after e0; `dma_busy` falls after it.
  - Total busy time is 3N+1 cycles. For `len=0`, busy time is 1 cycle.
- Each cycle with `sram_EN=1` while the engine is in `RD` or `WR` adds exactly one cycle of stall. `CAP` never stalls.
- `dma_start` in the same cycle as `DONE` is ignored. A new copy can be accepted from the first `IDLE` cycle.

## Test plan
- Read-first behaviour:
  - Stimulus: reset; CPU writes `0xDEADBEEF` to `0x0010`, then reads `0x0010`. Required: `sram_DO=0xDEADBEEF` in the cycle after the read.
  - Stimulus: in one cycle, write `0x1` to `0x0010` while reading `0x0010`. Required: `sram_DO` shows the old value next cycle.
- Uncontended copy:
  - Stimulus: preload `mem[0x100..0x103]={1,2,3,4}`; `dma_start` with src=`0x100`, dst=`0x200`, len=4, `sram_EN=0`.
  - Required: `dma_done` 13 cycles after start; `mem[0x200..0x203]={1,2,3,4}`; `dma_busy` high for exactly 13 cycles.
- Contended copy:
  - Stimulus: same copy while the CPU holds `sram_EN=1` on alternating cycles, with a CPU write of `0x55` to `0x101` before the engine reads it.
  - Required: no DMA write lands in any `sram_EN=1` cycle; `mem[0x201]=0x55`; each stall adds exactly one cycle to the completion time.
- Boundary cases:
  - `len=0`: `dma_done` one cycle after start, no memory change.
  - Wrap: src=`0xFFFE`, dst=`0x0010`, len=3 copies `mem[0xFFFE]`, `mem[0xFFFF]`, `mem[0x0000]`.
  - Overlap: src=`0x300`, dst=`0x301`, len=3, `mem[0x300]=7` gives `mem[0x301..0x303]=7`.
- `dma_start` during busy: ignored, and the in-flight copy's result is unchanged.
- Reset mid-copy:
  - Stimulus: reset after 2 of 4 words are written.
  - Required: `dma_busy=0`; `mem[dst]` and `mem[dst+1]` copied; `mem[dst+2]` and `mem[dst+3]` unchanged; `sram_DO=0`.
